// File: rtl/mod10_mon_pkg.sv
// Shared types and constants for the mod-10 digit-stream monitor.
package mod10_mon_pkg;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    UNSYNC,
    ACQUIRE,
    LOCK_UP,
    LOCK_DN
  } mon_state_e;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DN,
    JUMP
  } step_cls_e;

endpackage

// File: rtl/mod10_step_classifier.sv
// Combinational classification of one digit step against the previous legal digit (mod 10).
module mod10_step_classifier
  import mod10_mon_pkg::*;
(
  input  logic [3:0] prev_q_i,
  input  logic [3:0] q_i,
  output step_cls_e  cls_o,
  output logic       is_wrap_o,
  output logic       is_illegal_o
);

  logic [3:0] inc_digit;
  logic [3:0] dec_digit;

  always_comb begin
    inc_digit = (prev_q_i == MAX_DIGIT) ? 4'd0 : prev_q_i + 4'd1;
    dec_digit = (prev_q_i == 4'd0) ? MAX_DIGIT : prev_q_i - 4'd1;

    cls_o = JUMP;
    if (q_i == prev_q_i) begin
      cls_o = HOLD;
    end else if (q_i == inc_digit) begin
      cls_o = UP;
    end else if (q_i == dec_digit) begin
      cls_o = DN;
    end

    is_wrap_o    = ((prev_q_i == MAX_DIGIT) && (q_i == 4'd0)) ||
                   ((prev_q_i == 4'd0) && (q_i == MAX_DIGIT));
    is_illegal_o = (q_i > MAX_DIGIT);
  end

endmodule

// File: rtl/mod10_sequence_monitor.sv
// Receive-side monitor for a mod-10 up/down digit stream: direction lock, error pulses
// and saturating per-direction decade-wrap counters.
module mod10_sequence_monitor
  import mod10_mon_pkg::*;
#(
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [3:0]        q_in,
  input  logic              resync,
  output logic              locked,
  output logic              dir,
  output logic              step_err,
  output logic              code_err,
  output logic              reversal,
  output logic [WRAP_W-1:0] wrap_up_cnt,
  output logic [WRAP_W-1:0] wrap_dn_cnt,
  output logic [3:0]        prev_q
);

  localparam logic [WRAP_W-1:0] WrapOne = {{(WRAP_W-1){1'b0}}, 1'b1};

  mon_state_e        state_q;
  logic [2:0]        cnt_q;
  logic              cand_q;
  logic              locked_q;
  logic              dir_q;
  logic              step_err_q;
  logic              code_err_q;
  logic              reversal_q;
  logic [WRAP_W-1:0] wrap_up_q;
  logic [WRAP_W-1:0] wrap_dn_q;
  logic [3:0]        prev_q_q;

  step_cls_e         cls;
  logic              is_wrap;
  logic              is_illegal;
  logic              is_up;
  logic [3:0]        cnt_next;
  logic              lock_hit;
  logic [WRAP_W-1:0] wrap_up_inc;
  logic [WRAP_W-1:0] wrap_dn_inc;

  mod10_step_classifier u_classifier (
    .prev_q_i     (prev_q_q),
    .q_i          (q_in),
    .cls_o        (cls),
    .is_wrap_o    (is_wrap),
    .is_illegal_o (is_illegal)
  );

  always_comb begin
    is_up       = (cls == UP);
    // A step against the candidate direction restarts the run at one.
    cnt_next    = (is_up == cand_q) ? {1'b0, cnt_q} + 4'd1 : 4'd1;
    lock_hit    = (cnt_next >= 4'(LOCK_CNT));
    wrap_up_inc = (wrap_up_q == '1) ? wrap_up_q : wrap_up_q + WrapOne;
    wrap_dn_inc = (wrap_dn_q == '1) ? wrap_dn_q : wrap_dn_q + WrapOne;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNSYNC;
      cnt_q      <= 3'd0;
      cand_q     <= 1'b0;
      locked_q   <= 1'b0;
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
      code_err_q <= 1'b0;
      reversal_q <= 1'b0;
      wrap_up_q  <= '0;
      wrap_dn_q  <= '0;
      prev_q_q   <= 4'd0;
    end else begin
      step_err_q <= 1'b0;
      code_err_q <= 1'b0;
      reversal_q <= 1'b0;
      if (resync) begin
        state_q   <= UNSYNC;
        cnt_q     <= 3'd0;
        locked_q  <= 1'b0;
        wrap_up_q <= '0;
        wrap_dn_q <= '0;
      end else if (in_valid) begin
        if (is_illegal) begin
          code_err_q <= 1'b1;
          state_q    <= UNSYNC;
          locked_q   <= 1'b0;
        end else begin
          prev_q_q <= q_in;
          unique case (state_q)
            UNSYNC: begin
              state_q <= ACQUIRE;
              cnt_q   <= 3'd0;
            end
            ACQUIRE: begin
              if ((cls == UP) || (cls == DN)) begin
                cand_q <= is_up;
                cnt_q  <= cnt_next[2:0];
                if (lock_hit) begin
                  state_q  <= is_up ? LOCK_UP : LOCK_DN;
                  locked_q <= 1'b1;
                  dir_q    <= is_up;
                end
              end else if (cls == JUMP) begin
                cnt_q <= 3'd0;
              end
            end
            LOCK_UP: begin
              case (cls)
                UP: if (is_wrap) wrap_up_q <= wrap_up_inc;
                DN: begin
                  reversal_q <= 1'b1;
                  state_q    <= LOCK_DN;
                  dir_q      <= 1'b0;
                  cand_q     <= 1'b0;
                  if (is_wrap) wrap_dn_q <= wrap_dn_inc;
                end
                JUMP: begin
                  step_err_q <= 1'b1;
                  state_q    <= ACQUIRE;
                  cnt_q      <= 3'd0;
                  locked_q   <= 1'b0;
                end
                default: ;
              endcase
            end
            LOCK_DN: begin
              case (cls)
                DN: if (is_wrap) wrap_dn_q <= wrap_dn_inc;
                UP: begin
                  reversal_q <= 1'b1;
                  state_q    <= LOCK_UP;
                  dir_q      <= 1'b1;
                  cand_q     <= 1'b1;
                  if (is_wrap) wrap_up_q <= wrap_up_inc;
                end
                JUMP: begin
                  step_err_q <= 1'b1;
                  state_q    <= ACQUIRE;
                  cnt_q      <= 3'd0;
                  locked_q   <= 1'b0;
                end
                default: ;
              endcase
            end
            default: state_q <= UNSYNC;
          endcase
        end
      end
    end
  end

  assign locked      = locked_q;
  assign dir         = dir_q;
  assign step_err    = step_err_q;
  assign code_err    = code_err_q;
  assign reversal    = reversal_q;
  assign wrap_up_cnt = wrap_up_q;
  assign wrap_dn_cnt = wrap_dn_q;
  assign prev_q      = prev_q_q;

endmodule
